// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: register map, status
// layout, control bits and drain-FSM state encodings.
package uart_tx_buffer_pkg;

  // Word offset decoded from addr[7:1]. TXDATA is reached through uds, and
  // STATUS (read) / CONTROL (write) through lds, all at the same word.
  localparam logic [6:0] REG_WORD = 7'd0;

  // STATUS byte layout
  localparam int STAT_EMPTY_BIT = 7;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_COUNT_MSB = 4;

  // CONTROL bits
  localparam int CTRL_FLUSH_BIT = 0;

  typedef enum logic [1:0] {
    DRAIN_IDLE    = 2'd0,
    DRAIN_REQ     = 2'd1,
    DRAIN_RELEASE = 2'd2
  } drain_state_t;

  // Assemble the STATUS byte {empty, full, 0, count[4:0]}
  function automatic logic [7:0] status_byte(input logic       empty,
                                             input logic       full,
                                             input logic [4:0] count);
    logic [7:0] s;
    s = '0;
    s[STAT_EMPTY_BIT]     = empty;
    s[STAT_FULL_BIT]      = full;
    s[STAT_COUNT_MSB:0]   = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// 68000-style CPU bus port of the transmit buffer. The CPU is the master,
// the buffer is the slave.
interface uart_tx_buffer_if;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic [7:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic        ack;

  modport master (
    output data_write, addr, uds, lds, rw,
    input  data_read, ack
  );

  modport slave (
    input  data_write, addr, uds, lds, rw,
    output data_read, ack
  );
endinterface

// File: rtl/uart_tx_buffer_sync_fifo_cnt.sv
// Synchronous show-ahead FIFO with an occupancy counter and a flush input.
// Flush wins over a simultaneous push; pushes while full and pops while
// empty are ignored.
module sync_fifo_cnt #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push_ok;
  logic              pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign count    = count_q;
  assign data_out = mem[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer between the CPU bus and the UART register port. The CPU
// pushes bytes into a FIFO through TXDATA; a small drain FSM acts as a bus
// master on the UART RXTX register and sends one byte per UART frame.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_buffer_if.slave   bus,
  output logic [15:0]       m_data_write,
  output logic [7:0]        m_addr,
  output logic              m_uds,
  output logic              m_lds,
  output logic              m_rw,
  input  logic              m_ack,
  input  logic              tx_active,
  output logic              tx_idle
);

  // FIFO signals
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  logic [7:0]  fifo_head;
  logic        fifo_empty;
  logic        fifo_full;
  logic [AW:0] fifo_count;

  // CPU-side decode
  logic        hit;
  logic        lock_q;
  logic        accept;
  logic        wr_txdata;
  logic        do_ack;
  logic [15:0] rd_next;

  // Drain FSM
  drain_state_t state_q;
  drain_state_t state_d;
  logic         launch;

  // addr[0] is a byte address bit the word decode never looks at, and
  // CONTROL only defines its flush bit.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[0], bus.data_write[7:1]};

  sync_fifo_cnt #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DATA_W (8)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .data_in  (bus.data_write[15:8]),
    .data_out (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  // Bus decode: a TXDATA write stalls (no ack) while the registered count
  // says full, even if the drain pops in the same cycle.
  always_comb begin
    hit        = (bus.addr[7:1] == REG_WORD) && (bus.uds || bus.lds);
    accept     = hit && !lock_q;
    wr_txdata  = !bus.rw && bus.uds;
    do_ack     = accept && !(wr_txdata && fifo_full);
    fifo_push  = do_ack && wr_txdata;
    fifo_flush = do_ack && !bus.rw && bus.lds && bus.data_write[CTRL_FLUSH_BIT];
    rd_next    = '0;
    if (do_ack && bus.rw && bus.lds)
      rd_next = {8'h00, status_byte(fifo_empty, fifo_full, 5'(fifo_count))};
  end

  // Registered ack/read data, plus the lock that holds off a second access
  // until the CPU has released both strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ack       <= 1'b0;
      bus.data_read <= '0;
      lock_q        <= 1'b0;
    end else begin
      bus.ack       <= do_ack;
      bus.data_read <= rd_next;
      if (do_ack)
        lock_q <= 1'b1;
      else if (!bus.uds && !bus.lds)
        lock_q <= 1'b0;
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= DRAIN_IDLE;
    else          state_q <= state_d;
  end

  // Drain FSM next-state: wait for a byte and an idle UART, request, release
  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAIN_IDLE:    if (!fifo_empty && !tx_active) state_d = DRAIN_REQ;
      DRAIN_REQ:     if (m_ack) state_d = DRAIN_RELEASE;
      DRAIN_RELEASE: state_d = DRAIN_IDLE;
      default:       state_d = DRAIN_IDLE;
    endcase
  end

  // Drain FSM outputs; strobes depend on state only, never on m_ack
  always_comb begin
    m_uds    = (state_q == DRAIN_REQ);
    m_rw     = (state_q != DRAIN_REQ);
    m_lds    = 1'b0;
    m_addr   = '0;
    fifo_pop = (state_q == DRAIN_REQ) && m_ack;
    launch   = (state_q == DRAIN_IDLE) && (state_d == DRAIN_REQ);
    tx_idle  = fifo_empty && (state_q == DRAIN_IDLE) && !tx_active;
  end

  // Latch the head byte when a request starts so a flush cannot change it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    m_data_write <= '0;
    else if (launch) m_data_write <= {fifo_head, 8'h00};
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: a table of CPU bus accesses with hand-computed
// responses, then directed sequences for draining, full stall, flush,
// reset during a request and a held strobe. A small UART model answers the
// drain requests and records the bytes it receives.
module tb_uart_tx_buffer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_buffer_if bus();

  logic [15:0] m_data_write;
  logic [7:0]  m_addr;
  logic        m_uds, m_lds, m_rw, m_ack, tx_active, tx_idle;

  uart_tx_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .m_data_write (m_data_write),
    .m_addr       (m_addr),
    .m_uds        (m_uds),
    .m_lds        (m_lds),
    .m_rw         (m_rw),
    .m_ack        (m_ack),
    .tx_active    (tx_active),
    .tx_idle      (tx_idle)
  );

  int checks = 0;
  int failures = 0;

  // UART model controls and capture
  logic       force_busy;
  logic       stall;
  int         frame_len;
  int         tx_cnt;
  int         proto_err;
  logic [7:0] rxq[$];

  assign tx_active = force_busy || (tx_cnt != 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ack  <= 1'b0;
      tx_cnt <= 0;
    end else begin
      if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
      if (m_ack) m_ack <= 1'b0;
      else if (m_uds && !stall) begin
        m_ack <= 1'b1;
        rxq.push_back(m_data_write[15:8]);
        if (m_data_write[7:0] != 8'h00 || m_rw !== 1'b0 || m_lds !== 1'b0 || m_addr != 8'h00)
          proto_err <= proto_err + 1;
        tx_cnt <= frame_len;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, exp);
    end
  endtask

  // One CPU access: drive at a negedge, wait up to budget cycles for ack,
  // release the strobes and leave one idle cycle.
  task automatic cpu_op(input logic rw, input logic uds, input logic lds,
                        input logic [7:0] addr, input logic [15:0] wd, input int budget,
                        output logic got_ack, output logic [15:0] rd, output int lat);
    bus.rw = rw; bus.uds = uds; bus.lds = lds; bus.addr = addr; bus.data_write = wd;
    got_ack = 1'b0; rd = '0; lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.ack) begin
        got_ack = 1'b1; rd = bus.data_read; lat = i;
        break;
      end
    end
    bus.uds = 1'b0; bus.lds = 1'b0; bus.rw = 1'b1;
    @(negedge clk);
  endtask

  task automatic status_is(input string name, input logic [15:0] exp);
    logic a; logic [15:0] r; int l;
    cpu_op(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 6, a, r, l);
    check({name, "_ack"}, a, 1'b1);
    check(name, r, exp);
  endtask

  task automatic write_tx(input string name, input logic [15:0] wd);
    logic a; logic [15:0] r; int l;
    cpu_op(1'b0, 1'b1, 1'b0, 8'h00, wd, 6, a, r, l);
    check(name, a, 1'b1);
  endtask

  typedef struct {
    logic        rw, uds, lds;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        exp_ack;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic a; logic [15:0] r; int l; logic ok; int pulses;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 16'h0080}; // empty status
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hAA00, 1'b1, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 16'h0001};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0000}; // uds read
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hBB00, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 16'h0002};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h04, 16'hCC00, 1'b0, 16'h0000}; // not decoded
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h02, 16'h0000, 1'b0, 16'h0000}; // not decoded
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h01, 16'h0000, 1'b1, 16'h0002}; // addr[0] ignored
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 16'h00FE, 1'b1, 16'h0000}; // control, no flush
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 16'h0002};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 16'h7701, 1'b1, 16'h0000}; // push+flush
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 16'h0080};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'hDD00, 1'b1, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 16'h0001, 1'b1, 16'h0000}; // flush
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 16'h0080};

    bus.rw = 1'b1; bus.uds = 1'b0; bus.lds = 1'b0; bus.addr = '0; bus.data_write = '0;
    force_busy = 1'b0; stall = 1'b0; frame_len = 4; proto_err = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ack", bus.ack, 1'b0);
    check("rst_data_read", bus.data_read, 16'h0000);
    check("rst_m_data_write", m_data_write, 16'h0000);
    check("rst_m_uds", m_uds, 1'b0);
    check("rst_m_lds", m_lds, 1'b0);
    check("rst_m_rw", m_rw, 1'b1);
    check("rst_m_addr", m_addr, 8'h00);
    check("rst_tx_idle", tx_idle, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    // Register table with the UART held busy so nothing drains
    force_busy = 1'b1;
    for (int v = 0; v < 16; v++) begin
      cpu_op(vecs[v].rw, vecs[v].uds, vecs[v].lds, vecs[v].addr, vecs[v].wd, 6, a, r, l);
      check($sformatf("vec%0d_ack", v), a, vecs[v].exp_ack);
      if (vecs[v].exp_ack) begin
        check($sformatf("vec%0d_rd", v), r, vecs[v].exp_rd);
        check($sformatf("vec%0d_latency", v), l, 1);
      end
    end
    check("table_no_tx", rxq.size(), 0);

    // Single byte end to end
    force_busy = 1'b0; frame_len = 4;
    cpu_op(1'b0, 1'b1, 1'b0, 8'h00, 16'h4100, 6, a, r, l);
    check("single_ack", a, 1'b1);
    check("single_latency", l, 1);
    check("single_m_uds", m_uds, 1'b1);
    check("single_m_data", m_data_write, 16'h4100);
    check("single_m_rw", m_rw, 1'b0);
    check("single_tx_idle_busy", tx_idle, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_idle) begin ok = 1'b1; break; end
    end
    check("single_tx_idle", ok, 1'b1);
    check("single_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("single_rx_byte", rxq[0], 8'h41);
    check("single_m_rw_after", m_rw, 1'b1);

    // Burst of 16 to full, then a 17th write that must wait for a pop
    force_busy = 1'b1; frame_len = 3; rxq.delete();
    for (int k = 1; k <= 16; k++) write_tx($sformatf("burst%0d_ack", k), {k[7:0], 8'h00});
    status_is("burst_status", 16'h0050);
    bus.rw = 1'b0; bus.uds = 1'b1; bus.lds = 1'b0; bus.addr = 8'h00; bus.data_write = 16'h1100;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ack) pulses++;
    end
    check("full_wait_no_ack", pulses, 0);
    force_busy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ack) begin ok = 1'b1; break; end
    end
    check("full_late_ack", ok, 1'b1);
    check("full_pop_before_ack", rxq.size(), 1);
    bus.uds = 1'b0; bus.rw = 1'b1;
    @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rxq.size() >= 17 && tx_idle) begin ok = 1'b1; break; end
    end
    check("burst_drained", ok, 1'b1);
    check("burst_rx_count", rxq.size(), 17);
    for (int k = 0; k < 17 && k < rxq.size(); k++)
      check($sformatf("burst_rx%0d", k), rxq[k], k + 1);

    // Flush while a request is outstanding
    force_busy = 1'b1; rxq.delete();
    for (int k = 0; k < 5; k++) write_tx($sformatf("flush_fill%0d", k), {8'h21 + 8'(k), 8'h00});
    stall = 1'b1; force_busy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_uds) begin ok = 1'b1; break; end
    end
    check("flush_req_up", ok, 1'b1);
    check("flush_req_data", m_data_write, 16'h2100);
    cpu_op(1'b0, 1'b0, 1'b1, 8'h00, 16'h0001, 6, a, r, l);
    check("flush_ctrl_ack", a, 1'b1);
    status_is("flush_status", 16'h0080);
    stall = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("flush_rx_byte", rxq[0], 8'h21);
    check("flush_tx_idle", tx_idle, 1'b1);
    status_is("flush_status_after", 16'h0080);

    // Reset asserted while a request is outstanding
    force_busy = 1'b1; rxq.delete();
    write_tx("rstreq_fill", 16'h3300);
    stall = 1'b1; force_busy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_uds) begin ok = 1'b1; break; end
    end
    check("rstreq_req_up", ok, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rstreq_m_uds", m_uds, 1'b0);
    check("rstreq_ack", bus.ack, 1'b0);
    check("rstreq_m_data", m_data_write, 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; stall = 1'b0;
    @(negedge clk);
    status_is("rstreq_status", 16'h0080);
    repeat (20) @(negedge clk);
    check("rstreq_no_tx", rxq.size(), 0);
    check("rstreq_m_uds_idle", m_uds, 1'b0);

    // Held strobe: one push, one ack pulse
    force_busy = 1'b1;
    bus.rw = 1'b0; bus.uds = 1'b1; bus.lds = 1'b0; bus.addr = 8'h00; bus.data_write = 16'h5500;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ack) pulses++;
    end
    bus.uds = 1'b0; bus.rw = 1'b1;
    @(negedge clk);
    check("hold_ack_pulses", pulses, 1);
    status_is("hold_status", 16'h0001);
    force_busy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rxq.size() >= 1 && tx_idle) begin ok = 1'b1; break; end
    end
    check("hold_drained", ok, 1'b1);
    check("hold_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("hold_rx_byte", rxq[0], 8'h55);

    check("uart_protocol", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
